fetch_unit: RTL

- Parametrised, decoupled instruction-fetch stage for the next-generation core.
- Replaces the single-cycle PC + InstROM path with a prefetching front end that talks to a synchronous instruction memory and buffers words in a FIFO.
- Hands instructions plus their PCs to decode over a valid/ready handshake.
- Handles branch redirects, start/restart and halt detection, and keeps cycle and retired-instruction counters.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled, prefetching instruction-fetch stage.
//
// Issues reads to a synchronous instruction memory (data returns one cycle
// after imem_rd), buffers the returned words with their PCs in a small FIFO
// and presents the head to decode over a valid/ready handshake. Handles
// start/restart, branch redirects, halt detection and two saturating
// counters.
//
// Ports:
//   CLK, reset (async, active low)
//   start, start_addr           - (re)start fetching at start_addr
//   imem_addr, imem_rd          - memory read request
//   imem_data                   - read data, valid the cycle after imem_rd
//   instr_out, instr_pc         - FIFO head word and its PC
//   instr_valid, instr_ready    - decode handshake
//   redirect, redirect_pc       - taken branch / jump target
//   halt                        - halt word has been consumed
//   cycle_ct, instr_ct          - active cycles / accepted instructions
module fetch_unit #(
   parameter int                 PC_W       = 10,
   parameter int                 INSTR_W    = 9,
   parameter int                 DEPTH      = 4,
   parameter int                 CNT_W      = 16,
   parameter logic [INSTR_W-1:0] HALT_INSTR = '1
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   input  logic [PC_W-1:0]    start_addr,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_rd,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic [PC_W-1:0]    instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               halt,
   output logic [CNT_W-1:0]   cycle_ct,
   output logic [CNT_W-1:0]   instr_ct
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc;
   } entry_t;

   state_t          state, state_nx;
   entry_t          mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count;
   logic [PC_W-1:0] fetch_pc;
   // one-deep tracking of the outstanding read
   logic            rsp_vld, rsp_epoch, epoch;
   logic [PC_W-1:0] rsp_pc;

   logic            active, flush, push, pop, halt_push, halt_pop;
   logic [AW+1:0]   occ;

   assign active      = (state == RUN) || (state == DRAIN);
   // start acts in any state; redirect only while fetching or draining
   assign flush       = start | (redirect & active);
   // buffered words plus the read in flight bound the FIFO, so a push can
   // never find it full without a matching pop
   assign occ         = {1'b0, count} + (AW+2)'(rsp_vld);
   assign imem_rd     = (state == RUN) & ~start & ~redirect & (occ < (AW+2)'(DEPTH));
   assign imem_addr   = fetch_pc;

   // responses from a previous epoch or arriving after fetch stopped are dropped
   assign push        = rsp_vld & (rsp_epoch == epoch) & (state == RUN) & ~flush;
   assign instr_valid = (count != '0);
   assign pop         = instr_valid & instr_ready & ~flush;
   assign instr_out   = mem[rptr].instr;
   assign instr_pc    = mem[rptr].pc;
   assign halt_push   = push & (imem_data == HALT_INSTR);
   assign halt_pop    = pop & (state == DRAIN) & (instr_out == HALT_INSTR);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = IDLE;
         RUN:     if (halt_push) state_nx = DRAIN;
         DRAIN:   if (redirect) state_nx = RUN;
                  else if (halt_pop) state_nx = HALTED;
         HALTED:  state_nx = HALTED;
         default: state_nx = IDLE;
      endcase
      if (start) state_nx = RUN;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         fetch_pc  <= '0;
         epoch     <= 1'b0;
         rsp_vld   <= 1'b0;
         rsp_epoch <= 1'b0;
         rsp_pc    <= '0;
         halt      <= 1'b0;
         cycle_ct  <= '0;
         instr_ct  <= '0;
      end else begin
         rsp_vld   <= imem_rd;
         rsp_epoch <= epoch;
         rsp_pc    <= fetch_pc;

         if (flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            epoch    <= ~epoch;
            fetch_pc <= start ? start_addr : redirect_pc;
         end else begin
            if (push) begin
               mem[wptr] <= '{instr: imem_data, pc: rsp_pc};
               wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (imem_rd) fetch_pc <= fetch_pc + PC_W'(1);
         end

         if (start) begin
            halt     <= 1'b0;
            cycle_ct <= '0;
            instr_ct <= '0;
         end else begin
            if (halt_pop) halt <= 1'b1;
            if (active && cycle_ct != '1) cycle_ct <= cycle_ct + CNT_W'(1);
            if (pop && instr_ct != '1)    instr_ct <= instr_ct + CNT_W'(1);
         end
      end
   end

endmodule
